// File: rtl/mii_checker.sv
// MII receive-side frame checker: tracks frame boundaries, forwards payload
// bytes, classifies each closed frame and keeps saturating good/bad totals.
module mii_checker #(
    parameter logic [7:0] IDLE_CODE      = 8'h07,
    parameter logic [7:0] START_CODE     = 8'hFB,
    parameter logic [7:0] TERMINATE_CODE = 8'hFD,
    parameter int         MIN_LEN        = 46,
    parameter int         MAX_LEN        = 1500
) (
    input  logic        tx_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_ctrl,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_in_frame,
    output logic        o_frame_done,
    output logic        o_frame_ok,
    output logic [2:0]  o_err_code,
    output logic [10:0] o_frame_len,
    output logic        o_idle_err,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_bad_cnt,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_DROP = 2'd2} state_t;

    localparam logic [10:0] MIN_L  = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L  = 11'(MAX_LEN);
    localparam logic [10:0] OVER_L = 11'(MAX_LEN + 1);

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_SHORT = 3'd1;
    localparam logic [2:0] ERR_LONG  = 3'd2;
    localparam logic [2:0] ERR_RESTART = 3'd3;
    localparam logic [2:0] ERR_CTRL  = 3'd4;

    state_t      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic [10:0] len_inc;

    logic [7:0]  data_d;
    logic        dv_d, done_d, ok_d, ierr_d, good_inc, bad_inc;
    logic [2:0]  err_d;
    logic [10:0] flen_d;

    assign len_inc = len_q + 11'd1;
    assign o_state = state_q;

    always_ff @(posedge tx_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (i_rx_ctrl && i_rx_data == START_CODE) begin
                    state_d = S_DATA;
                    len_d   = '0;
                end
            end
            S_DATA: begin
                if (!i_rx_ctrl) begin
                    len_d = len_inc;
                    if (len_inc == OVER_L) state_d = S_DROP;
                end else if (i_rx_data == START_CODE) begin
                    len_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (i_rx_ctrl && (i_rx_data == TERMINATE_CODE || i_rx_data == IDLE_CODE)) begin
                    state_d = S_IDLE;
                end else if (i_rx_ctrl && i_rx_data == START_CODE) begin
                    state_d = S_DATA;
                    len_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                len_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs; pulses default low every cycle.
    always_comb begin
        data_d   = o_data;
        dv_d     = 1'b0;
        done_d   = 1'b0;
        ok_d     = 1'b0;
        err_d    = ERR_NONE;
        flen_d   = o_frame_len;
        ierr_d   = 1'b0;
        good_inc = 1'b0;
        bad_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!i_rx_ctrl || (i_rx_data != IDLE_CODE && i_rx_data != START_CODE))
                    ierr_d = 1'b1;
            end
            S_DATA: begin
                if (!i_rx_ctrl) begin
                    data_d = i_rx_data;
                    dv_d   = 1'b1;
                    if (len_inc == OVER_L) begin
                        done_d  = 1'b1;
                        err_d   = ERR_LONG;
                        flen_d  = OVER_L;
                        bad_inc = 1'b1;
                    end
                end else begin
                    done_d = 1'b1;
                    flen_d = len_q;
                    if (i_rx_data == TERMINATE_CODE) begin
                        if (len_q >= MIN_L && len_q <= MAX_L) begin
                            ok_d     = 1'b1;
                            good_inc = 1'b1;
                        end else begin
                            err_d   = ERR_SHORT;
                            bad_inc = 1'b1;
                        end
                    end else if (i_rx_data == START_CODE) begin
                        err_d   = ERR_RESTART;
                        bad_inc = 1'b1;
                    end else begin
                        err_d   = ERR_CTRL;
                        bad_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge tx_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_in_frame   <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_err_code   <= '0;
            o_frame_len  <= '0;
            o_idle_err   <= 1'b0;
            o_good_cnt   <= '0;
            o_bad_cnt    <= '0;
        end else begin
            o_data       <= data_d;
            o_data_valid <= dv_d;
            o_in_frame   <= (state_d == S_DATA);
            o_frame_done <= done_d;
            o_frame_ok   <= ok_d;
            o_err_code   <= err_d;
            o_frame_len  <= flen_d;
            o_idle_err   <= ierr_d;
            if (good_inc && o_good_cnt != 16'hFFFF) o_good_cnt <= o_good_cnt + 16'd1;
            if (bad_inc && o_bad_cnt != 16'hFFFF)   o_bad_cnt  <= o_bad_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mii_checker.sv
// Directed bench for mii_checker: good, short, long, restart, idle-error and
// mid-frame reset scenarios with hand-computed expectations.
module tb_mii_checker;

    logic        tx_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_ctrl;
    logic [7:0]  o_data;
    logic        o_data_valid;
    logic        o_in_frame;
    logic        o_frame_done;
    logic        o_frame_ok;
    logic [2:0]  o_err_code;
    logic [10:0] o_frame_len;
    logic        o_idle_err;
    logic [15:0] o_good_cnt;
    logic [15:0] o_bad_cnt;
    logic [1:0]  o_state;

    int total = 0;
    int bad = 0;
    int dv_seen;
    int done_seen;

    always #5 tx_clk = ~tx_clk;

    mii_checker dut (
        .tx_clk       (tx_clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_ctrl    (i_rx_ctrl),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_in_frame   (o_in_frame),
        .o_frame_done (o_frame_done),
        .o_frame_ok   (o_frame_ok),
        .o_err_code   (o_err_code),
        .o_frame_len  (o_frame_len),
        .o_idle_err   (o_idle_err),
        .o_good_cnt   (o_good_cnt),
        .o_bad_cnt    (o_bad_cnt),
        .o_state      (o_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one character; returns just after the edge that samples it.
    task automatic step(input logic c, input logic [7:0] d);
        @(negedge tx_clk);
        i_rx_ctrl = c;
        i_rx_data = d;
        @(posedge tx_clk);
        #1;
    endtask

    task automatic data_bytes(input int n, input logic [7:0] d);
        dv_seen   = 0;
        done_seen = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, d);
            if (o_data_valid && o_data == d) dv_seen++;
            if (o_frame_done) done_seen++;
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_rx_ctrl = 1'b1;
        i_rx_data = 8'h07;
        #12;
        chk("rst_in_frame", o_in_frame, 0);
        chk("rst_good", o_good_cnt, 0);
        chk("rst_bad", o_bad_cnt, 0);
        chk("rst_len", o_frame_len, 0);
        @(negedge tx_clk);
        i_rst = 1'b0;

        // Good frame
        step(1'b1, 8'h07);
        step(1'b1, 8'h07);
        chk("idle_no_err", o_idle_err, 0);
        step(1'b1, 8'hFB);
        chk("good_in_frame", o_in_frame, 1);
        chk("good_state", o_state, 1);
        data_bytes(46, 8'hAA);
        chk("good_dv_count", dv_seen, 46);
        chk("good_no_early_done", done_seen, 0);
        step(1'b1, 8'hFD);
        chk("good_done", o_frame_done, 1);
        chk("good_ok", o_frame_ok, 1);
        chk("good_err", o_err_code, 0);
        chk("good_len", o_frame_len, 46);
        chk("good_cnt", o_good_cnt, 1);
        chk("good_out_frame", o_in_frame, 0);
        step(1'b1, 8'h07);
        chk("good_done_pulse", o_frame_done, 0);
        chk("good_ok_clear", o_frame_ok, 0);
        chk("good_len_hold", o_frame_len, 46);
        chk("good_dv_low", o_data_valid, 0);
        chk("good_data_hold", o_data, 8'hAA);

        // Short frame
        step(1'b1, 8'hFB);
        data_bytes(10, 8'h5C);
        chk("short_dv_count", dv_seen, 10);
        step(1'b1, 8'hFD);
        chk("short_done", o_frame_done, 1);
        chk("short_ok", o_frame_ok, 0);
        chk("short_err", o_err_code, 1);
        chk("short_len", o_frame_len, 10);
        chk("short_bad", o_bad_cnt, 1);
        chk("short_good", o_good_cnt, 1);

        // Long frame: close on the 1501st byte, then DROP
        step(1'b1, 8'hFB);
        data_bytes(1500, 8'h33);
        chk("long_no_done_1500", done_seen, 0);
        chk("long_in_frame_1500", o_in_frame, 1);
        step(1'b0, 8'h44);
        chk("long_done", o_frame_done, 1);
        chk("long_err", o_err_code, 2);
        chk("long_len", o_frame_len, 1501);
        chk("long_bad", o_bad_cnt, 2);
        chk("long_dv_last", o_data_valid, 1);
        chk("long_in_frame", o_in_frame, 0);
        chk("long_state_drop", o_state, 2);
        step(1'b0, 8'h55);
        chk("drop_dv", o_data_valid, 0);
        chk("drop_done", o_frame_done, 0);
        chk("drop_data_hold", o_data, 8'h44);
        step(1'b1, 8'hFD);
        chk("drop_fd_done", o_frame_done, 0);
        chk("drop_fd_bad", o_bad_cnt, 2);
        chk("drop_fd_state", o_state, 0);

        // Restart
        step(1'b1, 8'hFB);
        data_bytes(20, 8'h11);
        step(1'b1, 8'hFB);
        chk("rs_done1", o_frame_done, 1);
        chk("rs_err1", o_err_code, 3);
        chk("rs_len1", o_frame_len, 20);
        chk("rs_bad", o_bad_cnt, 3);
        chk("rs_in_frame", o_in_frame, 1);
        data_bytes(46, 8'h22);
        chk("rs_no_mid_done", done_seen, 0);
        step(1'b1, 8'hFD);
        chk("rs_done2", o_frame_done, 1);
        chk("rs_ok2", o_frame_ok, 1);
        chk("rs_len2", o_frame_len, 46);
        chk("rs_good", o_good_cnt, 2);

        // Bad control inside a frame
        step(1'b1, 8'hFB);
        data_bytes(3, 8'h66);
        step(1'b1, 8'h07);
        chk("ctrl_done", o_frame_done, 1);
        chk("ctrl_err", o_err_code, 4);
        chk("ctrl_len", o_frame_len, 3);
        chk("ctrl_bad", o_bad_cnt, 4);
        chk("ctrl_state", o_state, 0);

        // Idle errors
        step(1'b0, 8'h12);
        chk("ie_pulse1", o_idle_err, 1);
        chk("ie_in_frame1", o_in_frame, 0);
        step(1'b1, 8'hFE);
        chk("ie_pulse2", o_idle_err, 1);
        chk("ie_good", o_good_cnt, 2);
        chk("ie_bad", o_bad_cnt, 4);
        step(1'b1, 8'h07);
        chk("ie_clear", o_idle_err, 0);

        // Reset mid-frame
        step(1'b1, 8'hFB);
        data_bytes(5, 8'h77);
        @(negedge tx_clk);
        i_rst = 1'b1;
        #1;
        chk("mrst_in_frame", o_in_frame, 0);
        chk("mrst_good", o_good_cnt, 0);
        chk("mrst_bad", o_bad_cnt, 0);
        chk("mrst_data", o_data, 0);
        chk("mrst_done", o_frame_done, 0);
        chk("mrst_len", o_frame_len, 0);
        chk("mrst_state", o_state, 0);
        @(negedge tx_clk);
        i_rst = 1'b0;
        step(1'b1, 8'hFB);
        data_bytes(46, 8'hAA);
        step(1'b1, 8'hFD);
        chk("post_done", o_frame_done, 1);
        chk("post_ok", o_frame_ok, 1);
        chk("post_len", o_frame_len, 46);
        chk("post_good", o_good_cnt, 1);
        chk("post_bad", o_bad_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mii_checker.md
MII_CHECKER -- requirements
Module: mii_checker

Interface
REQ-001 The module SHALL have parameter IDLE_CODE, default 8'h07, meaning the idle control character.
REQ-002 The module SHALL have parameter START_CODE, default 8'hFB, meaning the start-of-frame control character.
REQ-003 The module SHALL have parameter TERMINATE_CODE, default 8'hFD, meaning the end-of-frame control character.
REQ-004 The module SHALL have parameter MIN_LEN, default 46, meaning the minimum legal data bytes per frame.
REQ-005 The module SHALL have parameter MAX_LEN, default 1500, meaning the maximum legal data bytes per frame.
REQ-006 The module SHALL have port tx_clk, input, 1 bit: clock; all logic on its rising edge.
REQ-007 The module SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The module SHALL have port i_rx_data, input, 8 bits: MII character.
REQ-009 The module SHALL have port i_rx_ctrl, input, 1 bit: 1 = control character, 0 = data byte.
REQ-010 The module SHALL have port o_data, output, 8 bits: captured payload byte.
REQ-011 The module SHALL have port o_data_valid, output, 1 bit: o_data holds a payload byte this cycle.
REQ-012 The module SHALL have port o_in_frame, output, 1 bit: FSM is in DATA.
REQ-013 The module SHALL have port o_frame_done, output, 1 bit: single-cycle frame-closed pulse.
REQ-014 The module SHALL have port o_frame_ok, output, 1 bit: qualifies o_frame_done; 1 = good frame.
REQ-015 The module SHALL have port o_err_code, output, 3 bits: 0 none, 1 short, 2 long, 3 restart, 4 bad control.
REQ-016 The module SHALL have port o_frame_len, output, 11 bits: data byte count of the closed frame.
REQ-017 The module SHALL have port o_idle_err, output, 1 bit: single-cycle pulse on an illegal character in IDLE.
REQ-018 The module SHALL have ports o_good_cnt and o_bad_cnt, outputs, 16 bits each: good and bad frame totals.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, DATA and DROP.
REQ-020 All outputs SHALL be registered, changing on the rising edge that samples the causing input (visible one cycle after presentation).
REQ-021 In IDLE: ctrl=1 with IDLE_CODE -> stay in IDLE, no output.
REQ-022 In IDLE: ctrl=1 with START_CODE -> go to DATA and clear the length counter to 0.
REQ-023 In IDLE: ctrl=0, or ctrl=1 with any other code -> stay in IDLE and pulse o_idle_err; no frame counters change.
REQ-024 In DATA, ctrl=0: o_data <= i_rx_data, o_data_valid <= 1, and the length counter increments.
REQ-025 In DATA, if the byte just counted makes the length MAX_LEN+1: pulse o_frame_done with err 2, o_frame_len=MAX_LEN+1, o_bad_cnt++, and go to DROP.
REQ-026 In DATA, ctrl=1 with TERMINATE_CODE -> pulse o_frame_done and go to IDLE; the frame is ok/err 0 if MIN_LEN<=len<=MAX_LEN, else err 1; o_good_cnt++ or o_bad_cnt++ accordingly.
REQ-027 In DATA, ctrl=1 with START_CODE -> close the current frame with err 3 and o_bad_cnt++, clear the length to 0, and stay in DATA (new frame).
REQ-028 In DATA, ctrl=1 with any other code (including IDLE_CODE) -> close with err 4, o_bad_cnt++, and go to IDLE.
REQ-029 In DROP: ignore data bytes with no o_data_valid; TERMINATE_CODE or IDLE_CODE -> go to IDLE; START_CODE -> go to DATA with length 0; no further o_frame_done for the dropped frame.
REQ-030 When o_frame_done=1, o_frame_len SHALL hold the closed frame's byte count; it SHALL hold that value until the next close.
REQ-031 o_frame_ok and o_err_code SHALL be valid only while o_frame_done=1, and 0 otherwise.
REQ-032 o_data_valid SHALL be 0 in every cycle not covered by REQ-024; o_data SHALL hold its last value.
REQ-033 o_good_cnt and o_bad_cnt SHALL saturate at 16'hFFFF.
REQ-034 The length counter SHALL never exceed MAX_LEN+1.
REQ-035 o_in_frame SHALL be 1 exactly while the state is DATA.

Reset
REQ-036 While i_rst=1, the state SHALL be IDLE and all outputs and counters SHALL be 0, asynchronously.
REQ-037 Reset asserted mid-frame SHALL discard the frame with no o_frame_done pulse and no counter change.
REQ-038 After reset release, the first START_CODE SHALL begin a new frame.

Verification
REQ-039 Reset: assert i_rst mid-DATA -> all outputs 0 immediately; the following FB, 46xAA, FD yields one good frame.
REQ-040 Good frame: idles, FB, 46x8'hAA, FD -> 46 o_data_valid pulses with o_data=AA; o_frame_done=1, o_frame_ok=1, o_err_code=0, o_frame_len=46; o_good_cnt=1.
REQ-041 Short frame: FB, 10 data, FD -> o_frame_done with err 1, o_frame_len=10, o_bad_cnt=1.
REQ-042 Long frame: FB, 1501 data, FD -> o_frame_done with err 2 on the 1501st byte, then DROP; FD gives no second pulse; o_bad_cnt=1.
REQ-043 Restart: FB, 20 data, FB, 46 data, FD -> two o_frame_done pulses, first err 3 with len 20, second ok with len 46; good=1, bad=1.
REQ-044 Idle errors: in IDLE, ctrl=0 data 8'h12 then ctrl=1 8'hFE -> two o_idle_err pulses, counters unchanged, o_in_frame=0.
